exc_ctrl: RTL

- Trap sequencer directly upstream of cp0.
- Watches the decode/execute-stage instruction for syscall, break, teq and eret. Checks each trap against cp0 status mask bits.
- For a taken trap: flushes younger instructions, waits for older instructions to drain, then drives the cp0 write pulse (cp0_ena rising edge).
- Finally issues a one-cycle PC redirect, to the handler for traps or to EPC for eret.

---
 rtl/exc_ctrl_if.sv | 39 +++
 rtl/exc_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl_if.sv
// Trap-sequencer signal bundle: trap-stage instruction in, cp0 commit and PC redirect out.
// The slave modport is the exc_ctrl side; the master modport is the pipeline/cp0 side.
interface exc_ctrl_if;
    logic        id_valid;
    logic        id_syscall;
    logic        id_break;
    logic        id_teq;
    logic        id_eret;
    logic [31:0] teq_rs;
    logic [31:0] teq_rt;
    logic [31:0] id_pc;
    logic [31:0] cp0_status;
    logic [31:0] cp0_exc_addr;
    logic        busy;
    logic        flush;
    logic        cp0_ena;
    logic        cp0_exception;
    logic        cp0_eret;
    logic [4:0]  cp0_cause;
    logic [31:0] cp0_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] trap_count;
    logic [15:0] masked_count;

    modport master (
        output id_valid, id_syscall, id_break, id_teq, id_eret,
        output teq_rs, teq_rt, id_pc, cp0_status, cp0_exc_addr,
        input  busy, flush, cp0_ena, cp0_exception, cp0_eret, cp0_cause, cp0_pc,
        input  redirect_valid, redirect_pc, trap_count, masked_count
    );

    modport slave (
        input  id_valid, id_syscall, id_break, id_teq, id_eret,
        input  teq_rs, teq_rt, id_pc, cp0_status, cp0_exc_addr,
        output busy, flush, cp0_ena, cp0_exception, cp0_eret, cp0_cause, cp0_pc,
        output redirect_valid, redirect_pc, trap_count, masked_count
    );
endinterface

// File: rtl/exc_ctrl.sv
// Trap sequencer ahead of cp0: accept -> flush -> drain -> cp0 commit -> redirect.
// Optional taken/masked trap statistics are built when EXC_CTRL_STATS_EN is defined.
module exc_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] HANDLER_ADDR = 32'h00400004
) (
    input logic       clk,
    input logic       rst,
    exc_ctrl_if.slave bus
);

    localparam logic [4:0] CAUSE_SYS  = 5'b01000;
    localparam logic [4:0] CAUSE_BRK  = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ  = 5'b01101;
    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_COMMIT,
        S_WAIT,
        S_REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ena_q;
    logic        eret_q;
    logic [4:0]  cause_q;
    logic [31:0] pc_q;
    logic [31:0] epc_q;

    logic        req_trap;
    logic        req_take;
    logic        req_eret;
    logic [4:0]  req_cause;
    logic        idle;
    logic        accept;
    logic        hold;
    logic        unused_status;

    assign unused_status = ^bus.cp0_status[31:4];

    // Highest-priority flag decides alone; a masked winner does not fall through to a lower one.
    always_comb begin
        req_take  = 1'b0;
        req_eret  = 1'b0;
        req_cause = '0;
        req_trap  = bus.id_eret | bus.id_syscall | bus.id_break | bus.id_teq;
        if (bus.id_eret) begin
            req_take = 1'b1;
            req_eret = 1'b1;
        end else if (bus.id_syscall) begin
            req_take  = bus.cp0_status[0] & bus.cp0_status[1];
            req_cause = CAUSE_SYS;
        end else if (bus.id_break) begin
            req_take  = bus.cp0_status[0] & bus.cp0_status[2];
            req_cause = CAUSE_BRK;
        end else if (bus.id_teq) begin
            req_take  = (bus.teq_rs == bus.teq_rt) & bus.cp0_status[0] & bus.cp0_status[3];
            req_cause = CAUSE_TEQ;
        end
    end

    assign idle   = (state_q == S_IDLE);
    assign accept = rst & idle & bus.id_valid & req_take;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_INIT;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_COMMIT;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_COMMIT:   state_d = S_WAIT;
            S_WAIT:     state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // cp0_ena comes straight from a flop so cp0 sees a clean single edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ena_q   <= 1'b0;
            eret_q  <= 1'b0;
            cause_q <= '0;
            pc_q    <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ena_q   <= (state_d == S_COMMIT);
            if (accept) begin
                eret_q  <= req_eret;
                cause_q <= req_cause;
                pc_q    <= bus.id_pc;
            end
            if (state_q == S_WAIT) begin
                epc_q <= bus.cp0_exc_addr;
            end
        end
    end

    assign hold = ~idle;

    assign bus.busy           = hold | accept;
    assign bus.flush          = accept;
    assign bus.cp0_ena        = ena_q;
    assign bus.cp0_exception  = hold & ~eret_q;
    assign bus.cp0_eret       = hold & eret_q;
    assign bus.cp0_cause      = hold ? cause_q : '0;
    assign bus.cp0_pc         = hold ? pc_q : '0;
    assign bus.redirect_valid = (state_q == S_REDIRECT);
    assign bus.redirect_pc    = (state_q != S_REDIRECT) ? '0
                              : (eret_q ? epc_q : HANDLER_ADDR);

`ifdef EXC_CTRL_STATS_EN
    logic [15:0] trap_q;
    logic [15:0] masked_q;
    logic        masked;

    assign masked = rst & idle & bus.id_valid & req_trap & ~req_take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_q   <= '0;
            masked_q <= '0;
        end else begin
            if (accept && !req_eret && trap_q != '1) begin
                trap_q <= trap_q + 16'd1;
            end
            if (masked && masked_q != '1) begin
                masked_q <= masked_q + 16'd1;
            end
        end
    end

    assign bus.trap_count   = trap_q;
    assign bus.masked_count = masked_q;
`else
    logic unused_trap;
    assign unused_trap      = req_trap;
    assign bus.trap_count   = '0;
    assign bus.masked_count = '0;
`endif

endmodule
